ctrl_fmem_mac_seq: RTL

- Upstream control stage of the convolution engine.
- Loads F_SIZE filter coefficients from the input stream into fmem, then sequences one MAC pass over F_SIZE taps each time a full x window is available.
- Drives memory read addresses and accumulator controls, and raises conv_start when a y result sits in the accumulator.
- Feeds the xmem/output controller, which owns m_valid and conv_done.

---
 rtl/ctrl_fmem_mac_seq_pkg.sv | 20 ++
 rtl/ctrl_fmem_mac_seq_mod_counter.sv | 36 +++
 rtl/ctrl_fmem_mac_seq.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/ctrl_fmem_mac_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Package  : conv_pkg
//  Purpose  : Shared types and constants for the convolution control slice.
//  Revision : 1.0  initial release
// ============================================================================
package conv_pkg;

    localparam int MEM_RD_LAT = 1;

    typedef enum logic [2:0] {
        LOAD_F  = 3'd0,
        WAIT_X  = 3'd1,
        COMPUTE = 3'd2,
        DRAIN   = 3'd3,
        HOLD    = 3'd4
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/ctrl_fmem_mac_seq_mod_counter.sv
`default_nettype none
// ============================================================================
//  Module   : mod_counter
//  Purpose  : Modulo-(TERMINAL+1) up counter with enable, sync clear and
//             terminal-count flag.
//  Revision : 1.0  initial release
// ============================================================================
module mod_counter #(
    parameter int WIDTH    = 5,
    parameter int TERMINAL = 31
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_count,
    output logic             o_tc
);

    localparam logic [WIDTH-1:0] c_term = WIDTH'(TERMINAL);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= (r_count == c_term) ? '0 : r_count + 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_tc    = (r_count == c_term);

endmodule
`default_nettype wire

// File: rtl/ctrl_fmem_mac_seq.sv
`default_nettype none
// ============================================================================
//  Module   : ctrl_fmem_mac_seq
//  Purpose  : Loads filter coefficients into fmem, then sequences one MAC pass
//             per available x window and flags each completed y result.
//  Revision : 1.0  initial release
// ============================================================================
module ctrl_fmem_mac_seq
    import conv_pkg::*;
#(
    parameter int F_SIZE           = 32,
    parameter int F_MEM_ADDR_WIDTH = 5
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        f_valid,
    output logic                        f_ready,
    output logic                        fmem_wr_en,
    output logic [F_MEM_ADDR_WIDTH-1:0] fmem_wr_addr,
    input  logic                        xmem_full,
    input  logic                        x_advance,
    input  logic                        conv_done,
    output logic [F_MEM_ADDR_WIDTH-1:0] rd_addr,
    output logic                        mac_clr,
    output logic                        mac_en,
    output logic                        conv_start
);

    seq_state_t r_state, w_next_state;

    logic r_f_ready,    w_f_ready_next;
    logic r_issue,      w_issue_next;
    logic r_mac_clr,    w_mac_clr_next;
    logic r_conv_start, w_conv_start_next;
    logic r_pending,    w_pending_next;
    logic w_rd_clr;
    logic w_wr_tc;
    logic w_rd_tc;

    logic [MEM_RD_LAT-1:0] r_en_pipe;

    assign f_ready    = r_f_ready;
    assign fmem_wr_en = f_valid & r_f_ready;
    assign mac_clr    = r_mac_clr;
    assign conv_start = r_conv_start;
    assign mac_en     = r_en_pipe[MEM_RD_LAT-1];

    mod_counter #(
        .WIDTH    (F_MEM_ADDR_WIDTH),
        .TERMINAL (F_SIZE - 1)
    ) u_wr_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_en    (fmem_wr_en),
        .i_clr   (conv_done),
        .o_count (fmem_wr_addr),
        .o_tc    (w_wr_tc)
    );

    mod_counter #(
        .WIDTH    (F_MEM_ADDR_WIDTH),
        .TERMINAL (F_SIZE - 1)
    ) u_rd_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_en    (r_issue),
        .i_clr   (w_rd_clr),
        .o_count (rd_addr),
        .o_tc    (w_rd_tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= LOAD_F;
            r_f_ready    <= 1'b0;
            r_issue      <= 1'b0;
            r_mac_clr    <= 1'b0;
            r_conv_start <= 1'b0;
            r_pending    <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_f_ready    <= w_f_ready_next;
            r_issue      <= w_issue_next;
            r_mac_clr    <= w_mac_clr_next;
            r_conv_start <= w_conv_start_next;
            r_pending    <= w_pending_next;
        end
    end

    // Product read at issue time reaches the accumulator MEM_RD_LAT cycles later
    always_ff @(posedge clk) begin
        if (reset || conv_done) begin
            r_en_pipe <= '0;
        end else begin
            r_en_pipe[0] <= r_issue;
            for (int i = 1; i < MEM_RD_LAT; i++) begin
                r_en_pipe[i] <= r_en_pipe[i-1];
            end
        end
    end

    always_comb begin
        w_next_state      = r_state;
        w_issue_next      = 1'b0;
        w_mac_clr_next    = 1'b0;
        w_conv_start_next = 1'b0;
        w_pending_next    = r_pending;
        w_rd_clr          = 1'b0;

        case (r_state)
            LOAD_F: begin
                if (fmem_wr_en && w_wr_tc) begin
                    w_next_state = WAIT_X;
                end
            end
            WAIT_X: begin
                if (xmem_full) begin
                    w_next_state   = COMPUTE;
                    w_mac_clr_next = 1'b1;
                    w_rd_clr       = 1'b1;
                end
            end
            COMPUTE: begin
                if (x_advance) begin
                    w_pending_next = 1'b1;
                end
                // First COMPUTE cycle is the clear cycle; issuing starts after it
                if (!r_issue || !w_rd_tc) begin
                    w_issue_next = 1'b1;
                end else begin
                    w_next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (x_advance) begin
                    w_pending_next = 1'b1;
                end
                w_next_state      = HOLD;
                w_conv_start_next = 1'b1;
            end
            HOLD: begin
                if (x_advance || r_pending) begin
                    w_next_state   = COMPUTE;
                    w_mac_clr_next = 1'b1;
                    w_rd_clr       = 1'b1;
                    w_pending_next = 1'b0;
                end
            end
            default: begin
                w_next_state = LOAD_F;
            end
        endcase

        if (conv_done) begin
            w_next_state      = LOAD_F;
            w_issue_next      = 1'b0;
            w_mac_clr_next    = 1'b0;
            w_conv_start_next = 1'b0;
            w_pending_next    = 1'b0;
            w_rd_clr          = 1'b1;
        end

        w_f_ready_next = (w_next_state == LOAD_F);
    end

endmodule
`default_nettype wire
